// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU-to-memory bus master.
package mem_bus_pkg;

  localparam int BUS_W = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_CAPTURE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables, store data replication, misalignment
// detection and load data extraction with optional sign extension.
module mem_lane_align
  import mem_bus_pkg::*;
(
  input  logic [1:0]       size,
  input  logic             sign_ext,
  input  logic [1:0]       addr_lo,
  input  logic [BUS_W-1:0] wdata_in,
  input  logic [BUS_W-1:0] rdata_in,
  output logic [3:0]       byteenable,
  output logic [BUS_W-1:0] wdata_out,
  output logic             misaligned,
  output logic [BUS_W-1:0] rdata_out
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte      = rdata_in[{addr_lo, 3'b000} +: 8];
    rhalf      = addr_lo[1] ? rdata_in[31:16] : rdata_in[15:0];
    byteenable = 4'b0000;
    wdata_out  = wdata_in;
    misaligned = 1'b0;
    rdata_out  = '0;
    case (size)
      SIZE_BYTE: begin
        byteenable = 4'b0001 << addr_lo;
        wdata_out  = {4{wdata_in[7:0]}};
        rdata_out  = {{24{sign_ext & rbyte[7]}}, rbyte};
      end
      SIZE_HALF: begin
        byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_out  = {2{wdata_in[15:0]}};
        misaligned = addr_lo[0];
        rdata_out  = {{16{sign_ext & rhalf[15]}}, rhalf};
      end
      SIZE_WORD: begin
        byteenable = 4'b1111;
        misaligned = |addr_lo;
        rdata_out  = rdata_in;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_bus_master.sv
// CPU load/store to Avalon-style bus master with waitrequest stalls.
// Define MEMBUS_TIMEOUT_EN to abort with an error after MAX_WAIT stalled cycles.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [BUS_W-1:0] req_addr,
  input  logic [BUS_W-1:0] req_wdata,
  output logic             resp_valid,
  output logic [BUS_W-1:0] resp_rdata,
  output logic             resp_err,
  output logic [BUS_W-1:0] address,
  output logic             read,
  output logic             write,
  output logic [3:0]       byteenable,
  output logic [BUS_W-1:0] writedata,
  input  logic             waitrequest,
  input  logic [BUS_W-1:0] readdata
);

  state_e           state_q, state_d;
  logic             write_q, write_d;
  logic [1:0]       size_q, size_d;
  logic             sign_q, sign_d;
  logic [BUS_W-1:0] addr_q, addr_d;
  logic [BUS_W-1:0] wdata_q, wdata_d;
  logic [BUS_W-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             is_idle;
  logic             in_bus;
  logic [1:0]       align_size;
  logic [1:0]       align_addr;
  logic [3:0]       lane_be;
  logic [BUS_W-1:0] lane_wdata;
  logic [BUS_W-1:0] lane_rdata;
  logic             misaligned;
  logic             timeout_hit;

  assign is_idle = (state_q == ST_IDLE);
  assign in_bus  = (state_q == ST_BUS);

  // The aligner looks at the live request in IDLE and at the latched one otherwise
  assign align_size = is_idle ? req_size      : size_q;
  assign align_addr = is_idle ? req_addr[1:0] : addr_q[1:0];

  mem_lane_align u_align (
    .size       (align_size),
    .sign_ext   (sign_q),
    .addr_lo    (align_addr),
    .wdata_in   (wdata_q),
    .rdata_in   (readdata),
    .byteenable (lane_be),
    .wdata_out  (lane_wdata),
    .misaligned (misaligned),
    .rdata_out  (lane_rdata)
  );

`ifdef MEMBUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (is_idle) begin
      wait_cnt_d = '0;
    end else if (in_bus && waitrequest) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = in_bus && waitrequest && (wait_cnt_q == CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  localparam int unused_max_wait = MAX_WAIT;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          sign_d  = req_signed;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = misaligned;
          state_d = misaligned ? ST_DONE : ST_BUS;
        end
      end
      ST_BUS: begin
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (!waitrequest) begin
          state_d = write_q ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        rdata_d = lane_rdata;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      size_q  <= SIZE_BYTE;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Bus outputs come straight from state and latched fields, so an async reset drops them at once
  assign req_ready  = reset_n && is_idle;
  assign read       = in_bus && !write_q;
  assign write      = in_bus && write_q;
  assign address    = in_bus ? {addr_q[BUS_W-1:2], 2'b00} : '0;
  assign byteenable = in_bus ? lane_be : 4'b0000;
  assign writedata  = (in_bus && write_q) ? lane_wdata : '0;
  assign resp_valid = (state_q == ST_DONE);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master: directed loads/stores, stalls,
// misalignment, mid-transaction reset and (with MEMBUS_TIMEOUT_EN) timeout.
module tb_mem_bus_master;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  resp_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stall_left = 0;
  logic [31:0] slave_word = 32'h0;

  mem_bus_master #(.MAX_WAIT(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .address     (address),
    .read        (read),
    .write       (write),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Slave model: stalls for stall_left strobed cycles, returns data one cycle after an accepted read
  initial begin : slave
    logic hit;
    waitrequest = 1'b0;
    readdata    = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      hit = read && !waitrequest;
      if ((read || write) && waitrequest && stall_left > 0) stall_left--;
      @(posedge clk);
      #1;
      readdata    = hit ? slave_word : 32'hDEADBEEF;
      waitrequest = (stall_left > 0);
    end
  end

  // Monitor: every response pulse must match the head of the scoreboard, including its cycle
  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_resp: got resp_valid=1 expected no response");
        end else begin
          e = exp_q.pop_front();
          checkOutput("resp_rdata", resp_rdata, e.rdata);
          checkOutput("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          checkOutput("resp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic applyStimulus(input string name, input logic wr, input logic [1:0] sz,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdword, input int stalls, input int nbus,
                               input int lat, input logic err, input logic [31:0] exp_rdata,
                               input logic [3:0] exp_be, input logic [31:0] exp_wd);
    resp_t e;
    @(negedge clk);
    checkOutput({name, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    slave_word = rdword;
    stall_left = stalls;
    e.rdata = exp_rdata;
    e.err   = err;
    e.cyc   = cyc + lat;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = ~wr;
    req_size   = ~sz;
    req_signed = ~sgn;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = ~wdata;
    for (int k = 1; k <= nbus; k++) begin
      @(negedge clk);
      checkOutput({name, "_read"}, {31'b0, read}, {31'b0, !wr});
      checkOutput({name, "_write"}, {31'b0, write}, {31'b0, wr});
      checkOutput({name, "_address"}, address, {addr[31:2], 2'b00});
      checkOutput({name, "_byteenable"}, {28'b0, byteenable}, {28'b0, exp_be});
      if (wr) checkOutput({name, "_writedata"}, writedata, exp_wd);
    end
    @(negedge clk);
    checkOutput({name, "_read_off"}, {31'b0, read}, 32'd0);
    checkOutput({name, "_write_off"}, {31'b0, write}, 32'd0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_resp_timeout: got no response expected one within 20 cycles", name);
      exp_q.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = SIZE_WORD;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("rst_read", {31'b0, read}, 32'd0);
    checkOutput("rst_write", {31'b0, write}, 32'd0);
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_address", address, 32'd0);
    checkOutput("rst_byteenable", {28'b0, byteenable}, 32'd0);
    checkOutput("rst_writedata", writedata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_req_ready", {31'b0, req_ready}, 32'd1);

    $display("[TB] directed loads and stores");
    //             name       wr    size       sgn   addr          wdata         rdword        st nb lat err   exp_rdata     be       wd
    applyStimulus("lw",       1'b0, SIZE_WORD, 1'b0, 32'hBFC00004, 32'h0,        32'h12345678, 0, 1, 3, 1'b0, 32'h12345678, 4'b1111, 32'h0);
    applyStimulus("sb",       1'b1, SIZE_BYTE, 1'b0, 32'hBFC00013, 32'h000000AB, 32'h0,        0, 1, 2, 1'b0, 32'h0,        4'b1000, 32'hABABABAB);
    applyStimulus("lb",       1'b0, SIZE_BYTE, 1'b1, 32'hBFC00002, 32'h0,        32'h0080FF00, 0, 1, 3, 1'b0, 32'hFFFFFF80, 4'b0100, 32'h0);
    applyStimulus("lbu",      1'b0, SIZE_BYTE, 1'b0, 32'hBFC00002, 32'h0,        32'h0080FF00, 0, 1, 3, 1'b0, 32'h00000080, 4'b0100, 32'h0);
    applyStimulus("lh_mis",   1'b0, SIZE_HALF, 1'b1, 32'hBFC00001, 32'h0,        32'h0,        0, 0, 1, 1'b1, 32'h0,        4'b0000, 32'h0);
    applyStimulus("sw_stall", 1'b1, SIZE_WORD, 1'b0, 32'hBFC00020, 32'hCAFEF00D, 32'h0,        3, 4, 5, 1'b0, 32'h0,        4'b1111, 32'hCAFEF00D);
    applyStimulus("sh_hi",    1'b1, SIZE_HALF, 1'b0, 32'h00000006, 32'h1234BEEF, 32'h0,        0, 1, 2, 1'b0, 32'h0,        4'b1100, 32'hBEEFBEEF);
    applyStimulus("lh_hi",    1'b0, SIZE_HALF, 1'b1, 32'h00000002, 32'h0,        32'h80010000, 0, 1, 3, 1'b0, 32'hFFFF8001, 4'b1100, 32'h0);
    applyStimulus("lh_lo",    1'b0, SIZE_HALF, 1'b1, 32'h00000000, 32'h0,        32'hAAAA7FFF, 0, 1, 3, 1'b0, 32'h00007FFF, 4'b0011, 32'h0);
    applyStimulus("size11",   1'b0, 2'b11,     1'b0, 32'h00000100, 32'h0,        32'h0,        0, 0, 1, 1'b1, 32'h0,        4'b0000, 32'h0);
    applyStimulus("sw_mis",   1'b1, SIZE_WORD, 1'b0, 32'h00000102, 32'h11223344, 32'h0,        0, 0, 1, 1'b1, 32'h0,        4'b0000, 32'h0);
    applyStimulus("lb_stall", 1'b0, SIZE_BYTE, 1'b1, 32'h00000001, 32'h0,        32'h00009C00, 2, 3, 5, 1'b0, 32'hFFFFFF9C, 4'b0010, 32'h0);

`ifdef MEMBUS_TIMEOUT_EN
    $display("[TB] timeout on stuck waitrequest");
    applyStimulus("lw_tmo",   1'b0, SIZE_WORD, 1'b0, 32'h00000010, 32'h0,        32'h0,     1000, 4, 5, 1'b1, 32'h0,        4'b1111, 32'h0);
    stall_left = 0;
    @(negedge clk);
`endif

    $display("[TB] reset during BUS");
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_size   = SIZE_WORD;
    req_signed = 1'b0;
    req_addr   = 32'h00000040;
    stall_left = 1000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_read_before", {31'b0, read}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_read", {31'b0, read}, 32'd0);
    checkOutput("abort_address", address, 32'd0);
    checkOutput("abort_req_ready", {31'b0, req_ready}, 32'd0);
    stall_left = 0;
    repeat (2) @(negedge clk);
    checkOutput("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_release_ready", {31'b0, req_ready}, 32'd1);

    applyStimulus("lw_after", 1'b0, SIZE_WORD, 1'b0, 32'h00000008, 32'h0,        32'h55AA55AA, 0, 1, 3, 1'b0, 32'h55AA55AA, 4'b1111, 32'h0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 Parameter MAX_WAIT, default 255: consecutive waitrequest-high cycles before timeout; used only when MEMBUS_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  CPU access request.
REQ-005 req_ready  output  1  high only in IDLE; request accepted on the edge where req_valid && req_ready.
REQ-006 req_write  input  1  1 store, 0 load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word; 11 is treated as misaligned.
REQ-008 req_signed  input  1  sign-extend loads (lb/lh); ignored for word and stores.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  valid with resp_valid: misaligned or timeout.
REQ-014 address  output  32  word-aligned bus address, req_addr with bits [1:0] cleared.
REQ-015 read, write  output  1 each  bus strobes, never both high.
REQ-016 byteenable  output  4  lane k (bits 8k+7:8k) = byte offset k.
REQ-017 writedata  output  32  store data shifted into enabled lanes.
REQ-018 waitrequest  input  1  slave stall.
REQ-019 readdata  input  32  slave read data, fixed latency 1.

Function
REQ-020 States: IDLE, BUS, CAPTURE, DONE.
REQ-021 IDLE: on acceptance, latch all req_* fields; go to DONE with error if misaligned (half with addr[0]=1, word with addr[1:0]!=0, size 11), else go to BUS.
REQ-022 BUS: drive read or write, address, byteenable and writedata from latched fields; hold them unchanged while waitrequest=1.
REQ-023 BUS exit on waitrequest=0: loads go to CAPTURE, stores go to DONE.
REQ-024 CAPTURE: read=0; readdata registered at the end of the cycle.
REQ-025 DONE: resp_valid=1 for exactly one cycle, then IDLE; req_ready=0 in DONE.
REQ-026 Zero-wait latency: acceptance edge = cycle 0; store resp_valid in cycle 2; load resp_valid in cycle 3; misaligned resp_valid in cycle 1 with no bus strobe.
REQ-027 byteenable: byte 1<<addr[1:0]; half 0011 or 1100 by addr[1]; word 1111.
REQ-028 writedata: byte replicated into all four lanes, half replicated into both halves, word unchanged.
REQ-029 Load extraction: select lane(s) by latched addr[1:0], zero-extend, or sign-extend when req_signed=1.
REQ-030 Each waitrequest stall adds exactly one cycle of latency.

Reset
REQ-031 reset_n low asynchronously forces IDLE and clears read, write, resp_valid, resp_err, resp_rdata, byteenable, address, writedata and the wait counter.
REQ-032 req_ready is 0 while reset_n is low and 1 on the first cycle after release.
REQ-033 Reset mid-transaction aborts it immediately; no resp_valid is produced for the aborted request.

Configuration
REQ-034 With MEMBUS_TIMEOUT_EN defined: a counter increments each BUS cycle with waitrequest=1; on reaching MAX_WAIT, drop strobes and go to DONE with resp_err=1.
REQ-035 Without MEMBUS_TIMEOUT_EN: no counter is instantiated and BUS waits indefinitely.

Structure
REQ-036 Package mem_bus_pkg holds the state enum, the req_size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the bus width constant.
REQ-037 Combinational sub-module mem_lane_align computes byteenable, shifted writedata, the misalignment flag and extended load data; the FSM remains in mem_bus_master.

Verification
REQ-038 lw addr 0xBFC00004, readdata 0x12345678, no wait -> address 0xBFC00004, byteenable 1111, resp_rdata 0x12345678, resp_valid in cycle 3.
REQ-039 sb addr 0xBFC00013, wdata 0x000000AB -> address 0xBFC00010, byteenable 1000, writedata 0xABABABAB, resp_valid in cycle 2.
REQ-040 lb then lbu at addr 0xBFC00002, readdata 0x0080FF00 -> resp_rdata 0xFFFFFF80, then 0x00000080.
REQ-041 lh addr 0xBFC00001 -> read stays 0, resp_err=1, resp_valid in cycle 1.
REQ-042 sw with waitrequest high for 3 cycles -> write, address and writedata stable for 4 BUS cycles, resp_valid 3 cycles later than the zero-wait case.
REQ-043 With macro and MAX_WAIT=4, waitrequest stuck high -> strobes drop after 4 cycles, resp_err=1; separately, reset_n low during BUS -> read=0 immediately and no resp_valid.
